hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised per-register hazard scoreboard for the ID stage of the pipelined CPU. It replaces the single-cycle load-use check with a countdown scoreboard that supports any fixed producer latency and also unknown latency, such as a cache-miss load or an iterative divider. It records each issuing instruction's destination and required wait. It stalls later RAW consumers and WAW writers until the value is forwardable or written back. It sits beside the ID/EX register and drives the same stall net (PC hold, IF/ID hold, ID/EX bubble).

## Interface
Parameters:
- REG_AW, 5, register address width; NUM_REGS = 2**REG_AW (derived, not overridable)
- CNT_W, 3, latency counter width; value 2**CNT_W-1 (LAT_UNK) is reserved for unknown latency
- ZERO_REG, 1, when 1, register 0 is never tracked and never causes a hazard

Ports:
- clk_i, input, 1, clock; all state updates on rising edge
- rst_i, input, 1, synchronous active-high reset
- id_valid_i, input, 1, a valid instruction is in ID
- id_rs1_i / id_rs2_i, input, REG_AW, source register addresses
- id_rs1_used_i / id_rs2_used_i, input, 1, instruction actually reads rs1 / rs2
- id_rd_i, input, REG_AW, destination register address
- id_regwrite_i, input, 1, instruction writes rd
- id_lat_i, input, CNT_W, cycles a consumer must wait after issue: 0 = forwardable next cycle, not tracked; LAT_UNK = wait for wb release
- flush_i, input, 1, ID instruction is being killed; blocks issue and masks stall
- wb_valid_i, input, 1, unknown-latency result for wb_rd_i completes this cycle
- wb_rd_i, input, REG_AW, register being released
- stall_o, output, 1, hold PC and IF/ID, insert bubble into ID/EX
- stall_raw_o, output, 1, stall caused by rs1 or rs2
- stall_waw_o, output, 1, stall caused by rd
- pending_o, output, NUM_REGS, bit r set when cnt[r] != 0

## Operation
- State: one CNT_W-bit counter cnt[r] per register. Any nonzero value means the register is pending.
- Lookup, combinational on current state:
  - raw1 = id_rs1_used_i && tracked(rs1) && cnt[rs1] != 0
  - raw2 is the same check for rs2.
  - waw = id_regwrite_i && tracked(rd) && cnt[rd] > id_lat_i. LAT_UNK compares as the maximum value.
- Stall outputs:
  - stall_raw_o = id_valid_i && !flush_i && (raw1 || raw2)
  - stall_waw_o = id_valid_i && !flush_i && waw
  - stall_o = stall_raw_o || stall_waw_o
- Issue:
  - Condition: id_valid_i && !flush_i && !stall_o && id_regwrite_i && tracked(id_rd_i).
  - Action: cnt[id_rd_i] <= id_lat_i. With id_lat_i = 0 this clears any residual count.
- Per-cycle update for every other register r, in priority order:
  - If cnt[r] == LAT_UNK and wb_valid_i && wb_rd_i == r, then cnt[r] <= 0.
  - Else if cnt[r] == LAT_UNK, hold.
  - Else if cnt[r] != 0, decrement by 1.
  - Else hold at 0.
- Priority when events coincide: issue to r beats wb release of r and beats decrement of r.
- wb_valid_i on a register that is not LAT_UNK is ignored; the counter still decrements.
- Register 0 with ZERO_REG=1: counter is held at 0, issue is ignored, and the register never hazards.
- The ">" comparison on the full CNT_W width is unsigned.

## Timing
- Reset: all cnt = 0, so pending_o = 0 and stall_o / stall_raw_o / stall_waw_o = 0 (no ID activity, no stall) from the first cycle after reset.
- rst_i mid-operation clears every pending entry, including LAT_UNK, on the next edge. A later wb_valid_i for a cleared register is ignored.
- Stall outputs are purely combinational from inputs and state; there is no added latency.
- Issue at edge t with lat = k (1 ≤ k < LAT_UNK):
  - Consumer in ID during cycles t+1 … t+k stalls.
  - Consumer proceeds at cycle t+k+1.
  - k = 1 reproduces classic load-use with forwarding.
- LAT_UNK issued at edge t: consumers stall from t+1 until the cycle after the edge where wb_valid_i/wb_rd_i releases the register.
- Stall and issue are exclusive in the same cycle, so a stalled instruction records nothing. It re-evaluates every cycle while held in ID.
- flush_i forces all stall outputs low and blocks issue that cycle. Pending counters still update.

## Test plan
- Reset then idle: rst_i for 2 cycles → pending_o = 0, stall_o = 0, with id_valid_i both low and high on independent registers.
- Load-use: issue rd=5 with lat=1, then next ID reads rs1=5 → stall_o = 1 for exactly 1 cycle, stall_raw_o = 1, then 0. Same with lat=3 → 3 stall cycles. With lat=0 → no stall.
- Unknown latency: issue rd=7 with LAT_UNK, consumer rs2=7 held 10 cycles → stall 10 cycles. Pulse wb_valid_i with wb_rd_i=7 → stall drops next cycle and pending_o[7] = 0. A wb_valid_i for rd=8 in between has no effect.
- WAW: rd=9 pending LAT_UNK, new writer rd=9 with lat=1 → stall_waw_o = 1 until release. Writer with lat=2 while cnt[9]=1 → no stall, and cnt[9] becomes 2.
- Zero register and flush: issue rd=0 with lat=3, then read rs1=0 → no stall, pending_o[0] = 0. Raise flush_i while a RAW hazard is present → stall_o = 0 and no entry recorded.
- Corner cases:
  - Issue rd=4 with LAT_UNK in the same cycle as wb_valid_i/wb_rd_i=4 releases the old entry → cnt[4] = LAT_UNK.
  - rst_i with 3 registers pending → all cleared next cycle.

Source files
------------

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// hazard_scoreboard: per-register countdown scoreboard driving the ID stall.
// Revision: 1.0
// ============================================================================
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int CNT_W    = 3,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   id_valid_i,
  input  logic [REG_AW-1:0]      id_rs1_i,
  input  logic [REG_AW-1:0]      id_rs2_i,
  input  logic                   id_rs1_used_i,
  input  logic                   id_rs2_used_i,
  input  logic [REG_AW-1:0]      id_rd_i,
  input  logic                   id_regwrite_i,
  input  logic [CNT_W-1:0]       id_lat_i,
  input  logic                   flush_i,
  input  logic                   wb_valid_i,
  input  logic [REG_AW-1:0]      wb_rd_i,
  output logic                   stall_o,
  output logic                   stall_raw_o,
  output logic                   stall_waw_o,
  output logic [(2**REG_AW)-1:0] pending_o
);

  localparam int               c_num_regs = 2**REG_AW;
  localparam logic [CNT_W-1:0] c_lat_unk  = '1;

  logic [CNT_W-1:0] r_cnt [c_num_regs];
  logic [CNT_W-1:0] w_cnt_nxt [c_num_regs];

  logic w_raw1;
  logic w_raw2;
  logic w_waw;
  logic w_go;
  logic w_issue;

  function automatic logic f_tracked(input logic [REG_AW-1:0] a);
    return !(ZERO_REG && (a == '0));
  endfunction

  // All-ones encodes unknown latency, so the unsigned compare treats it as max.
  assign w_raw1 = id_rs1_used_i && f_tracked(id_rs1_i) && (r_cnt[id_rs1_i] != '0);
  assign w_raw2 = id_rs2_used_i && f_tracked(id_rs2_i) && (r_cnt[id_rs2_i] != '0);
  assign w_waw  = id_regwrite_i && f_tracked(id_rd_i) && (r_cnt[id_rd_i] > id_lat_i);

  assign w_go        = id_valid_i && !flush_i;
  assign stall_raw_o = w_go && (w_raw1 || w_raw2);
  assign stall_waw_o = w_go && w_waw;
  assign stall_o     = stall_raw_o || stall_waw_o;

  assign w_issue = w_go && !stall_o && id_regwrite_i && f_tracked(id_rd_i);

  always_comb begin
    for (int r = 0; r < c_num_regs; r++) begin
      w_cnt_nxt[r] = r_cnt[r];
      pending_o[r] = (r_cnt[r] != '0);
      if (ZERO_REG && (r == 0)) begin
        w_cnt_nxt[r] = '0;
      end else if (w_issue && (id_rd_i == REG_AW'(r))) begin
        w_cnt_nxt[r] = id_lat_i;
      end else if (r_cnt[r] == c_lat_unk) begin
        // Unknown-latency entries only leave via an explicit writeback release.
        if (wb_valid_i && (wb_rd_i == REG_AW'(r))) begin
          w_cnt_nxt[r] = '0;
        end
      end else if (r_cnt[r] != '0) begin
        w_cnt_nxt[r] = r_cnt[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < c_num_regs; r++) begin
        r_cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < c_num_regs; r++) begin
        r_cnt[r] <= w_cnt_nxt[r];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// tb_hazard_scoreboard: directed vector table plus a release-handshake sequence.
// Revision: 1.0
// ============================================================================
module tb_hazard_scoreboard;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        rw;
    logic [2:0]  lat;
    logic        fl;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        e_raw;
    logic        e_waw;
    logic [31:0] e_pend;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        id_rs1_used_i;
  logic        id_rs2_used_i;
  logic [4:0]  id_rd_i;
  logic        id_regwrite_i;
  logic [2:0]  id_lat_i;
  logic        flush_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        stall_o;
  logic        stall_raw_o;
  logic        stall_waw_o;
  logic [31:0] pending_o;

  int n_total = 0;
  int n_bad   = 0;
  int cur     = 0;
  vec_t vecs[$];

  always #5 clk_i = ~clk_i;

  hazard_scoreboard #(.REG_AW(5), .CNT_W(3), .ZERO_REG(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i), .id_lat_i(id_lat_i),
    .flush_i(flush_i), .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
    .stall_o(stall_o), .stall_raw_o(stall_raw_o), .stall_waw_o(stall_waw_o),
    .pending_o(pending_o)
  );

  function automatic logic [31:0] p(input int n);
    return 32'd1 << n;
  endfunction

  function automatic vec_t row(input logic rst, input logic v,
                               input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic [4:0] rd, input logic rw, input logic [2:0] lat,
                               input logic fl, input logic wbv, input logic [4:0] wbrd,
                               input logic er, input logic ew, input logic [31:0] ep);
    vec_t t;
    t.rst = rst; t.valid = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
    t.rd = rd; t.rw = rw; t.lat = lat; t.fl = fl; t.wbv = wbv; t.wbrd = wbrd;
    t.e_raw = er; t.e_waw = ew; t.e_pend = ep;
    return t;
  endfunction

  // Shorthands: idle cycle, writer issuing rd/lat, reader of rs1.
  function automatic vec_t nop(input logic [31:0] ep);
    return row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ep);
  endfunction
  function automatic vec_t wr(input logic [4:0] rd, input logic [2:0] lat,
                              input logic ew, input logic [31:0] ep);
    return row(0, 1, 0, 0, 0, 0, rd, 1, lat, 0, 0, 0, 0, ew, ep);
  endfunction
  function automatic vec_t rd1(input logic [4:0] rs, input logic er, input logic [31:0] ep);
    return row(0, 1, rs, 1, 0, 0, 0, 0, 0, 0, 0, 0, er, 0, ep);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step=%0d actual=%h expected=%h", name, cur, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst_i = t.rst; id_valid_i = t.valid;
    id_rs1_i = t.rs1; id_rs1_used_i = t.u1; id_rs2_i = t.rs2; id_rs2_used_i = t.u2;
    id_rd_i = t.rd; id_regwrite_i = t.rw; id_lat_i = t.lat;
    flush_i = t.fl; wb_valid_i = t.wbv; wb_rd_i = t.wbrd;
  endtask

  task automatic apply(input vec_t t);
    drive(t);
    #2;
    chk("stall_raw", 32'(stall_raw_o), 32'(t.e_raw));
    chk("stall_waw", 32'(stall_waw_o), 32'(t.e_waw));
    chk("stall", 32'(stall_o), 32'(t.e_raw | t.e_waw));
    chk("pending", pending_o, t.e_pend);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Idle and independent traffic after reset
    vecs.push_back(nop(0));
    vecs.push_back(row(0, 1, 3, 1, 6, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0));
    // Load-use, lat=1
    vecs.push_back(wr(5, 1, 0, 0));
    vecs.push_back(rd1(5, 1, p(5)));
    vecs.push_back(rd1(5, 0, 0));
    // lat=3
    vecs.push_back(wr(5, 3, 0, 0));
    vecs.push_back(rd1(5, 1, p(5)));
    vecs.push_back(rd1(5, 1, p(5)));
    vecs.push_back(rd1(5, 1, p(5)));
    vecs.push_back(rd1(5, 0, 0));
    // lat=0 is never tracked
    vecs.push_back(wr(5, 0, 0, 0));
    vecs.push_back(rd1(5, 0, 0));
    // Unknown latency on r7, consumer on rs2, release in the 10th stalled cycle
    vecs.push_back(wr(7, 7, 0, 0));
    for (int i = 0; i < 10; i++) begin
      vecs.push_back(row(0, 1, 0, 0, 7, 1, 0, 0, 0, 0,
                         (i == 4 || i == 9), (i == 4) ? 5'd8 : 5'd7, 1, 0, p(7)));
    end
    vecs.push_back(row(0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // WAW against unknown latency, then shorter-than-pending writers
    vecs.push_back(wr(9, 7, 0, 0));
    vecs.push_back(wr(9, 1, 1, p(9)));
    vecs.push_back(row(0, 1, 0, 0, 0, 0, 9, 1, 1, 0, 1, 9, 0, 1, p(9)));
    vecs.push_back(wr(9, 1, 0, 0));
    vecs.push_back(wr(9, 2, 0, p(9)));
    vecs.push_back(nop(p(9)));
    vecs.push_back(nop(p(9)));
    vecs.push_back(nop(0));
    // Zero register
    vecs.push_back(wr(0, 3, 0, 0));
    vecs.push_back(row(0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    // Flush masks stall and blocks issue; wb on a counting entry is ignored
    vecs.push_back(wr(12, 2, 0, 0));
    vecs.push_back(row(0, 1, 12, 1, 0, 0, 13, 1, 3, 1, 1, 12, 0, 0, p(12)));
    vecs.push_back(nop(p(12)));
    vecs.push_back(nop(0));
    // Re-issue of r4 at LAT_UNK coinciding with its release
    vecs.push_back(wr(4, 7, 0, 0));
    vecs.push_back(row(0, 1, 0, 0, 0, 0, 4, 1, 7, 0, 1, 4, 0, 0, p(4)));
    vecs.push_back(nop(p(4)));
    vecs.push_back(nop(p(4)));
    // Reset with three registers pending
    vecs.push_back(wr(20, 7, 0, p(4)));
    vecs.push_back(wr(21, 5, 0, p(4) | p(20)));
    vecs.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, p(4) | p(20) | p(21)));
    vecs.push_back(nop(0));
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0));
    vecs.push_back(rd1(4, 0, 0));

    drive(nop(0));
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      cur = i;
      apply(vecs[i]);
    end

    // Held consumer on r15 re-evaluates each cycle; release must drop stall next cycle.
    cur = 1000;
    apply(wr(15, 7, 0, 0));
    drive(rd1(15, 1, 0));
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("held_stall", 32'(stall_o), 32'd1);
      @(posedge clk_i);
      #1;
    end
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd15;
    @(posedge clk_i);
    #1;
    wb_valid_i = 1'b0;
    begin
      int waited;
      waited = 0;
      while (stall_o && waited < 8) begin
        @(posedge clk_i);
        #1;
        waited++;
      end
      chk("release_latency", 32'(waited), 32'd0);
      chk("release_pending", 32'(pending_o[15]), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
